// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map, STATUS layout, TX FSM states.
// Latency: not applicable (type and constant definitions only).
// Backpressure: not applicable.
package uart_mmio_pkg;

    // Word offsets within the register block, taken from aluout[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    // STATUS register bit positions
    localparam int ST_BUSY     = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_COUNT    = 4;   // 4-bit field, bits [7:4]

    // Serialiser states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // The STATUS count field is only four bits wide, so deeper FIFOs saturate at 15
    function automatic logic [3:0] sat_count(input int unsigned n);
        if (n > 32'd15) begin
            return 4'hF;
        end
        return n[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Generic synchronous FIFO with occupancy count; push and pop may coincide even when full.
// Latency: a pushed word is visible at the head (pop_dat) one edge after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop when empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: address decode, registers, TX FIFO, baud counter and serialiser.
// Latency: register reads are combinational (zero cycles); a byte pushed into an idle block starts its start bit after the next edge.
// Backpressure: none toward the core; a TXDATA write to a full FIFO with no pop that cycle is dropped and sets sticky overflow.
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sel,
    output logic        txd,
    output logic        tx_idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Address decode and write strobes
    logic [1:0]    offset;
    logic          wr_en;
    logic          fifo_push;

    // FIFO interface
    logic          fifo_pop;
    logic [7:0]    fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Register file
    logic          overflow;
    logic [15:0]   baud_div;

    // Serialiser state
    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    // Read data assembly
    logic [31:0]   status_word;

    // Upper data bits and byte-offset address bits have no meaning in this register block
    logic          unused_bits;
    assign unused_bits = ^{writedata[31:16], aluout[1:0]};

    assign sel       = (aluout[31:4] == BASE_ADDR[31:4]);
    assign offset    = aluout[3:2];
    assign wr_en     = memwrite && sel;
    assign fifo_push = wr_en && (offset == REG_TXDATA);

    // Last cycle of the current bit period; the counter is reloaded from baud_div at every bit start
    assign bit_end   = (baud_cnt == 16'd1);

    // Head is taken when idle, or at the end of a stop bit so the next start bit follows with no gap
    assign fifo_pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    assign tx_idle   = fifo_empty && (state == S_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (writedata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Writable registers: sticky overflow (cleared by any STATUS write) and baud divisor (0 coerced to 1)
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (wr_en && (offset == REG_STATUS)) begin
                overflow <= 1'b0;
            end else if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (wr_en && (offset == REG_BAUDDIV)) begin
                baud_div <= (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
            end
        end
    end

    // STATUS word built from current state; count reflects the FIFO after the previous edge
    always_comb begin
        status_word                      = '0;
        status_word[ST_BUSY]             = (state != S_IDLE);
        status_word[ST_FULL]             = fifo_full;
        status_word[ST_EMPTY]            = fifo_empty;
        status_word[ST_OVERFLOW]         = overflow;
        status_word[ST_COUNT +: 4]       = sat_count(32'(fifo_count));
    end

    // Combinational read mux; zero whenever the block is not addressed
    always_comb begin
        readdata = '0;
        if (sel) begin
            case (offset)
                REG_STATUS:  readdata = status_word;
                REG_BAUDDIV: readdata = {16'd0, baud_div};
                default:     readdata = '0;
            endcase
        end
    end

    // Serialiser: start bit, eight data bits LSB first, stop bit; each bit lasts baud_div cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            baud_cnt <= 16'd1;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shreg    <= fifo_dat;
                        txd      <= 1'b0;
                        baud_cnt <= baud_div;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        txd      <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_idx  <= 3'd0;
                        baud_cnt <= baud_div;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= baud_div;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            shreg    <= fifo_dat;
                            txd      <= 1'b0;
                            baud_cnt <= baud_div;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register behaviour, exact serial waveforms and a byte scoreboard.
// Latency: checks are taken 1 time unit after each rising edge; the serial monitor samples on falling edges.
// Backpressure: exercises FIFO full, overflow drop and push-on-pop acceptance.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE      = 32'hFFFF_FF00;
    localparam logic [31:0] A_TXDATA  = BASE;
    localparam logic [31:0] A_STATUS  = BASE + 32'd4;
    localparam logic [31:0] A_BAUD    = BASE + 32'd8;
    localparam logic [31:0] A_RSVD    = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sel;
    logic        txd;
    logic        tx_idle;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  sb[$];
    logic        exp_bits[$];
    int          mon_div  = 434;
    bit          mon_en   = 1'b1;

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .sel       (sel),
        .txd       (txd),
        .tx_idle   (tx_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        cycle();
        memwrite  = 1'b0;
        aluout    = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        aluout = a;
        #1;
        d      = readdata;
        aluout = 32'h0;
    endtask

    // Expected txd sequence of one 8N1 frame, one entry per clock
    task automatic add_frame(input logic [7:0] b, input int d);
        for (int k = 0; k < d; k++) exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < d; k++) exp_bits.push_back(b[i]);
        end
        for (int k = 0; k < d; k++) exp_bits.push_back(1'b1);
    endtask

    task automatic expect_wave(input string tag);
        int n;
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), {31'd0, txd}, {31'd0, exp_bits.pop_front()});
            cycle();
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(tx_idle === 1'b1 && sb.size() == 0) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, {31'd0, (n < budget)}, 32'd1);
    endtask

    // Serial monitor: decode each frame mid-bit and compare with the scoreboard head
    initial begin : serial_monitor
        logic [7:0] got;
        logic       start_ok;
        logic       stop_ok;
        int         d;
        forever begin
            @(negedge clk);
            if (mon_en && reset === 1'b0 && txd === 1'b0) begin
                d = mon_div;
                repeat (d / 2) @(negedge clk);
                start_ok = (txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    got[i] = txd;
                end
                repeat (d) @(negedge clk);
                stop_ok = (txd === 1'b1);
                if (mon_en) begin
                    check("mon_start_bit", {31'd0, start_ok}, 32'd1);
                    check("mon_stop_bit", {31'd0, stop_ok}, 32'd1);
                    check("mon_frame_expected", {31'd0, (sb.size() != 0)}, 32'd1);
                    if (sb.size() != 0) begin
                        check("mon_frame_byte", {24'd0, got}, {24'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] r;
        int          lows;

        reset     = 1'b1;
        memwrite  = 1'b0;
        aluout    = 32'h0;
        writedata = 32'h0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state and register map
        rd(A_STATUS, r);  check("reset_status", r, 32'h0000_0004);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_tx_idle", {31'd0, tx_idle}, 32'd1);
        rd(A_BAUD, r);    check("reset_bauddiv", r, 32'd434);
        cycle();
        rd(A_RSVD, r);    check("rsvd_read", r, 32'd0);
        rd(A_TXDATA, r);  check("txdata_read", r, 32'd0);
        aluout = 32'hFFFF_FE08;
        #1;
        check("miss_sel", {31'd0, sel}, 32'd0);
        check("miss_readdata", readdata, 32'd0);
        aluout = A_RSVD;
        #1;
        check("hit_sel", {31'd0, sel}, 32'd1);
        cycle();

        // Single frame 0x55 at div=4, exact waveform
        wr(A_BAUD, 32'd4);
        rd(A_BAUD, r);    check("bauddiv_rw", r, 32'd4);
        mon_div = 4;
        wr(A_TXDATA, 32'h55);
        sb.push_back(8'h55);
        rd(A_STATUS, r);  check("status_after_push", r, 32'h0000_0010);
        cycle();
        rd(A_STATUS, r);  check("status_after_pop", r, 32'h0000_0005);
        check("tx_idle_busy", {31'd0, tx_idle}, 32'd0);
        add_frame(8'h55, 4);
        expect_wave("wave55");
        check("idle_after_frame", {31'd0, tx_idle}, 32'd1);
        check("txd_after_frame", {31'd0, txd}, 32'd1);

        // Nine back-to-back writes: first pops immediately, FIFO ends full
        for (int i = 0; i < 9; i++) begin
            wr(A_TXDATA, 32'h10 + 32'(i));
            sb.push_back(8'(8'h10 + i));
        end
        rd(A_STATUS, r);  check("status_full", r, 32'h0000_0083);
        wr(A_TXDATA, 32'hEE);
        rd(A_STATUS, r);  check("status_overflow", r, 32'h0000_008B);
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, r);  check("status_ovf_cleared", r, 32'h0000_0083);
        repeat (30) cycle();
        rd(A_STATUS, r);  check("status_before_pop", r, 32'h0000_0083);
        wr(A_TXDATA, 32'hAB);
        sb.push_back(8'hAB);
        rd(A_STATUS, r);  check("status_push_on_pop", r, 32'h0000_0083);
        wait_drain("drain_full_fifo", 1000);

        // Two queued bytes at div=2: stop bit of the first runs straight into the second start bit
        wr(A_BAUD, 32'd2);
        mon_div = 2;
        wr(A_TXDATA, 32'hA5);
        wr(A_TXDATA, 32'h3C);
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        add_frame(8'hA5, 2);
        add_frame(8'h3C, 2);
        expect_wave("wave_b2b");
        check("idle_after_b2b", {31'd0, tx_idle}, 32'd1);
        wait_drain("drain_b2b", 100);

        // Divisor 0 stored as 1: ten-cycle frame
        wr(A_BAUD, 32'd0);
        rd(A_BAUD, r);    check("bauddiv_zero", r, 32'd1);
        mon_div = 1;
        wr(A_TXDATA, 32'h96);
        sb.push_back(8'h96);
        cycle();
        add_frame(8'h96, 1);
        expect_wave("wave_div1");
        check("idle_after_div1", {31'd0, tx_idle}, 32'd1);
        wait_drain("drain_div1", 100);

        // Reset during DATA bit 3 of 0xC3 with two more bytes queued
        wr(A_BAUD, 32'd4);
        mon_en = 1'b0;
        wr(A_TXDATA, 32'hC3);
        wr(A_TXDATA, 32'h5A);
        wr(A_TXDATA, 32'h0F);
        repeat (16) cycle();
        check("mid_data_bit3", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        cycle();
        check("abort_txd", {31'd0, txd}, 32'd1);
        rd(A_STATUS, r);  check("abort_status", r, 32'h0000_0004);
        check("abort_tx_idle", {31'd0, tx_idle}, 32'd1);
        reset = 1'b0;
        rd(A_BAUD, r);    check("abort_bauddiv", r, 32'd434);
        lows = 0;
        repeat (200) begin
            cycle();
            if (txd !== 1'b1) lows++;
        end
        check("no_frames_after_reset", 32'(lows), 32'd0);
        rd(A_STATUS, r);  check("final_status", r, 32'h0000_0004);
        mon_en = 1'b1;

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
